// File: rtl/rvv_backend_rob_byp_track_pkg.sv
// rtl/rvv_backend_rob_byp_track_pkg.sv - shared backend types for ROB bypass tracking
`ifndef ROB_DEPTH
`define ROB_DEPTH 8
`endif
`ifndef VLENB
`define VLENB 16
`endif

package rvv_backend_rob_byp_track_pkg;

    localparam int TRK_ROB_DEPTH = `ROB_DEPTH;
    localparam int TRK_VLENB     = `VLENB;

    typedef enum logic [1:0] {
        BODY_ACTIVE   = 2'd0,
        BODY_INACTIVE = 2'd1,
        TAIL          = 2'd2,
        NOT_CHANGE    = 2'd3
    } BYTE_TYPE_t;

    typedef struct packed {
        logic [8*TRK_VLENB-1:0]           w_data;
        BYTE_TYPE_t [TRK_VLENB-1:0]       byte_type;
        logic                             inactive_one;
        logic                             tail_one;
    } ROB_BYP_t;

    typedef struct packed {
        logic [TRK_ROB_DEPTH-1:0] vs1_hit;
        logic [TRK_ROB_DEPTH-1:0] vs2_hit;
        logic [TRK_ROB_DEPTH-1:0] vd_hit;
        logic [TRK_ROB_DEPTH-1:0] v0_hit;
    } RAW_UOP_ROB_t;

    typedef struct packed {
        logic                             vld;
        logic                             done;
        logic                             vd_valid;
        logic [4:0]                       vd_index;
        logic [8*TRK_VLENB-1:0]           w_data;
        BYTE_TYPE_t [TRK_VLENB-1:0]       byte_type;
        logic                             inactive_one;
        logic                             tail_one;
    } ROB_TRK_SLOT_t;

endpackage

// File: rtl/rvv_backend_youngest_match.sv
// rtl/rvv_backend_youngest_match.sv - youngest matching slot in age order from head
module rvv_backend_youngest_match
    import rvv_backend_rob_byp_track_pkg::*;
#(
    parameter int DEPTH = TRK_ROB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_match,
    input  logic [PTR_W-1:0] i_head,
    input  logic [DEPTH-1:0] i_done,
    output logic [DEPTH-1:0] o_onehot,
    output logic             o_pending
);

    logic             w_found;
    logic [PTR_W-1:0] w_sel;
    logic [PTR_W-1:0] w_idx;

    // Walk from head toward tail; the last match seen is the youngest.
    always_comb begin
        w_found   = 1'b0;
        w_sel     = '0;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if (i_match[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
        o_onehot = '0;
        if (w_found && i_done[w_sel])
            o_onehot[w_sel] = 1'b1;
        o_pending = w_found & ~i_done[w_sel];
    end

endmodule

// File: rtl/rvv_backend_rob_byp_track.sv
// rtl/rvv_backend_rob_byp_track.sv - in-flight uop tracker feeding dispatch bypass and RAW stall
module rvv_backend_rob_byp_track
    import rvv_backend_rob_byp_track_pkg::*;
#(
    parameter int ROB_DEPTH = `ROB_DEPTH,
    parameter int VLENB     = `VLENB,
    parameter int PTR_W     = $clog2(ROB_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic                         alloc_vd_valid,
    input  logic [4:0]                   alloc_vd_index,
    output logic [PTR_W-1:0]             alloc_rob_idx,
    input  logic                         wb_valid,
    input  logic [PTR_W-1:0]             wb_rob_idx,
    input  logic [8*VLENB-1:0]           wb_data,
    input  BYTE_TYPE_t [VLENB-1:0]       wb_byte_type,
    input  logic                         wb_inactive_one,
    input  logic                         wb_tail_one,
    output logic                         retire_valid,
    input  logic                         retire_ready,
    output logic                         retire_vd_valid,
    output logic [4:0]                   retire_vd_index,
    output logic [8*VLENB-1:0]           retire_data,
    output BYTE_TYPE_t [VLENB-1:0]       retire_byte_type,
    input  logic                         q_vs1_valid,
    input  logic [4:0]                   q_vs1_index,
    input  logic                         q_vs2_valid,
    input  logic [4:0]                   q_vs2_index,
    input  logic                         q_vd_valid,
    input  logic [4:0]                   q_vd_index,
    input  logic                         q_v0_valid,
    output ROB_BYP_t                     rob_byp [ROB_DEPTH],
    output RAW_UOP_ROB_t                 raw_uop_rob,
    output logic                         raw_stall
);

    ROB_TRK_SLOT_t      r_slot [ROB_DEPTH];
    logic [PTR_W:0]     r_head;
    logic [PTR_W:0]     r_tail;

    logic [PTR_W-1:0]   w_head;
    logic [PTR_W-1:0]   w_tail;
    logic               w_full;
    logic               w_alloc_fire;
    logic               w_retire_fire;
    logic [ROB_DEPTH-1:0] w_done;
    logic [ROB_DEPTH-1:0] w_match [4];
    logic [ROB_DEPTH-1:0] w_hit   [4];
    logic [3:0]         w_pend;
    logic [3:0]         w_q_valid;
    logic [4:0]         w_q_index [4];

    assign w_head        = r_head[PTR_W-1:0];
    assign w_tail        = r_tail[PTR_W-1:0];
    assign w_full        = (w_head == w_tail) && (r_head[PTR_W] != r_tail[PTR_W]);
    assign alloc_ready   = ~w_full;
    assign alloc_rob_idx = w_tail;
    assign w_alloc_fire  = alloc_valid & ~w_full;
    assign retire_valid  = r_slot[w_head].vld & r_slot[w_head].done;
    assign w_retire_fire = retire_valid & retire_ready;

    assign retire_vd_valid  = r_slot[w_head].vd_valid;
    assign retire_vd_index  = r_slot[w_head].vd_index;
    assign retire_data      = r_slot[w_head].w_data;
    assign retire_byte_type = r_slot[w_head].byte_type;

    // Retire is applied last so it wins if a late writeback hits the retiring slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < ROB_DEPTH; i++)
                r_slot[i] <= '0;
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < ROB_DEPTH; i++)
                r_slot[i] <= '0;
        end else begin
            if (wb_valid && r_slot[wb_rob_idx].vld) begin
                r_slot[wb_rob_idx].done         <= 1'b1;
                r_slot[wb_rob_idx].w_data       <= wb_data;
                r_slot[wb_rob_idx].byte_type    <= wb_byte_type;
                r_slot[wb_rob_idx].inactive_one <= wb_inactive_one;
                r_slot[wb_rob_idx].tail_one     <= wb_tail_one;
            end
            if (w_alloc_fire) begin
                r_slot[w_tail].vld      <= 1'b1;
                r_slot[w_tail].done     <= 1'b0;
                r_slot[w_tail].vd_valid <= alloc_vd_valid;
                r_slot[w_tail].vd_index <= alloc_vd_index;
                r_tail                  <= r_tail + (PTR_W+1)'(1);
            end
            if (w_retire_fire) begin
                r_slot[w_head] <= '0;
                r_head         <= r_head + (PTR_W+1)'(1);
            end
        end
    end

    assign w_q_valid    = {q_v0_valid, q_vd_valid, q_vs2_valid, q_vs1_valid};
    assign w_q_index[0] = q_vs1_index;
    assign w_q_index[1] = q_vs2_index;
    assign w_q_index[2] = q_vd_index;
    assign w_q_index[3] = 5'd0;

    always_comb begin
        for (int s = 0; s < 4; s++)
            w_match[s] = '0;
        w_done = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            w_done[i] = r_slot[i].done;
            for (int s = 0; s < 4; s++)
                w_match[s][i] = r_slot[i].vld & r_slot[i].vd_valid & w_q_valid[s]
                              & (r_slot[i].vd_index == w_q_index[s]);
        end
    end

    for (genvar s = 0; s < 4; s++) begin : g_src
        rvv_backend_youngest_match #(
            .DEPTH (ROB_DEPTH),
            .PTR_W (PTR_W)
        ) u_youngest (
            .i_match   (w_match[s]),
            .i_head    (w_head),
            .i_done    (w_done),
            .o_onehot  (w_hit[s]),
            .o_pending (w_pend[s])
        );
    end

    assign raw_uop_rob.vs1_hit = w_hit[0];
    assign raw_uop_rob.vs2_hit = w_hit[1];
    assign raw_uop_rob.vd_hit  = w_hit[2];
    assign raw_uop_rob.v0_hit  = w_hit[3];
    assign raw_stall           = |w_pend;

    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            rob_byp[i].w_data       = r_slot[i].w_data;
            rob_byp[i].byte_type    = r_slot[i].byte_type;
            rob_byp[i].inactive_one = r_slot[i].inactive_one;
            rob_byp[i].tail_one     = r_slot[i].tail_one;
        end
    end

endmodule

// File: doc/rvv_backend_rob_byp_track.md
# rvv_backend_rob_byp_track

Tracks in-flight vector uops between dispatch and retire as a circular buffer of `ROB_DEPTH` slots. It holds each uop's destination index, its completion state and its writeback data. It publishes per-slot bypass records and per-source RAW hit vectors to the dispatch bypass mux, and asserts a stall when a source depends on an uop that has not yet written back. It sits beside the ROB, upstream of the dispatch operand-bypass stage.

## Interface
Parameters:
- `ROB_DEPTH`, default `` `ROB_DEPTH `` (8): slot count, power of two.
- `VLENB`, default `` `VLENB `` (16): bytes per vector register.
- `PTR_W`, default `$clog2(ROB_DEPTH)`: slot index width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: trap/kill; empties the buffer.
- `alloc_valid` in 1, `alloc_ready` out 1: dispatch allocation handshake.
- `alloc_vd_valid` in 1: uop writes a vector register.
- `alloc_vd_index` in 5: destination register.
- `alloc_rob_idx` out PTR_W: slot granted; equals the tail pointer.
- `wb_valid` in 1, `wb_rob_idx` in PTR_W: writeback from a processing unit.
- `wb_data` in 8*VLENB, `wb_byte_type` in BYTE_TYPE_t[VLENB], `wb_inactive_one` in 1, `wb_tail_one` in 1: writeback payload.
- `retire_valid` out 1, `retire_ready` in 1: head retire handshake.
- `retire_vd_valid` out 1, `retire_vd_index` out 5, `retire_data` out 8*VLENB, `retire_byte_type` out BYTE_TYPE_t[VLENB]: head contents.
- `q_vs1_valid`/`q_vs1_index`, `q_vs2_valid`/`q_vs2_index`, `q_vd_valid`/`q_vd_index`, `q_v0_valid` in 1/5 each: dispatch source query; the v0 index is fixed at 0.
- `rob_byp` out ROB_BYP_t[ROB_DEPTH]: per-slot bypass record.
- `raw_uop_rob` out RAW_UOP_ROB_t: `vs1_hit`, `vs2_hit`, `vd_hit`, `v0_hit`.
- `raw_stall` out 1: a queried source has an incomplete producer.

## Operation
- Slot state: `vld` (allocated), `done` (written back), `vd_valid`, `vd_index`, `w_data`, `byte_type`, `inactive_one`, `tail_one`. Head and tail pointers are PTR_W+1 bits wide; the extra MSB is a wrap bit.
- Full = pointer low bits equal and MSBs differ. Empty = pointers equal.
- `alloc_ready = !full`. A retire in the same cycle does not free a slot for allocation.
- On allocation fire: the slot gets `vld=1`, `done=0` and the vd fields; the tail advances.
- On `wb_valid`: the payload is written and `done=1`, only if the addressed slot has `vld=1`. Writeback to an unallocated slot is ignored.
- `retire_valid = vld[head] & done[head]`. On fire the slot is cleared and the head advances.
- Query per source S:
  - Candidates are slots with `vld & vd_valid & vd_index==S_index & S_valid`.
  - `S_hit` is one-hot: only the youngest candidate, nearest the tail in age order across wrap, is set.
  - `S_hit` is all-zero when the youngest candidate has `done=0`.
- `raw_stall` = OR over sources of (youngest candidate exists & `!done`).
- `rob_byp[i]` is driven from the slot registers: `w_data`, `byte_type`, `inactive_one`, `tail_one`. Undone slots carry stale data; the hit gating prevents it from being used.
- Priority: `flush` > retire/wb/alloc. Retire, writeback and alloc touch distinct slots, because retire requires `done` and alloc requires `!vld`.

## Timing
- Reset and flush: both pointers 0, all `vld`/`done` 0.
  - `alloc_ready=1`, `alloc_rob_idx=0`, `retire_valid=0`.
  - Hits all 0, `raw_stall=0`.
  - `rob_byp` data and `byte_type` zero.
- Writeback is visible in `rob_byp`, hit vectors and `retire_valid` on the cycle after `wb_valid`.
- Query-to-hit/stall path is combinational with zero latency.
- Allocation affects queries from the next cycle. A same-cycle dispatch pair is resolved by the dispatch stage, not here.
- Reset asserted mid-operation clears state asynchronously. Outputs return to their reset values within the same cycle.

## Structure
- BYTE_TYPE_t, ROB_BYP_t and RAW_UOP_ROB_t stay in the shared backend package/svh. The slot record struct is added there as ROB_TRK_SLOT_t.
- Sub-module `rvv_backend_youngest_match`: given a match vector, a head pointer and a done vector, it returns the one-hot youngest slot and a pending flag. It is instantiated four times, once per source.

## Test plan
- Reset: release `rst_n`. Require `alloc_ready=1`, `alloc_rob_idx=0`, all hits 0, `raw_stall=0`.
- Producer pending, then done:
  - Allocate vd=v3 in slot 0, then query vs2=v3. Require `vs2_hit=0` and `raw_stall=1`.
  - Write back `wb_data=0xA5…` to slot 0. The next cycle requires `vs2_hit=8'b0000_0001` and `raw_stall=0`.
- Youngest of two producers:
  - Slot 1 (done) and slot 2 both target v5; query vd=v5. Require `vd_hit=0` and `raw_stall=1`.
  - After slot 2 is done, require `vd_hit=8'b0000_0100`.
- Wrap-around:
  - Fill 8 slots, retire 3, allocate 3 more with the same vd=v7 in slots 0..2, all done. Query v7.
  - Require `hit=8'b0000_0100`, with slot 2 as the youngest across the wrap.
- Full/retire boundary:
  - With 8 allocated, require `alloc_ready=0`.
  - Retire with `alloc_valid` held in the same cycle: no allocation occurs. The next cycle requires `alloc_ready=1`.
- Flush/stray writeback:
  - `wb_valid` to an unallocated slot 4 produces no `done` and no `retire_valid`.
  - Assert `flush` with 5 live slots. The next cycle requires empty, all hits 0, `alloc_rob_idx=0`.
